// File: rtl/bidir_bus_master_pkg.sv
// Shared types for the bidirectional bus master: FSM states, default width,
// and the response FIFO pointer-width helper.
package bidir_bus_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        RECOVER = 2'd3
    } state_e;

    function automatic int fifo_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/bidir_bus_master_if.sv
// Command/response stream bundle between the system interconnect and the
// bus master; the master modport is the bus master's own view.
interface bidir_bus_master_if
    import bidir_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_data;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;

    modport master (
        input  cmd_valid, cmd_write, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/bidir_bus_master_rsp_fifo.sv
// Read-response FIFO: power-of-two depth, wrapping pointers, occupancy count.
module bbm_rsp_fifo
    import bidir_bus_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [DATA_W-1:0]            push_data,
    input  logic                         pop,
    output logic [DATA_W-1:0]            pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [fifo_ptr_w(DEPTH):0]   count
);

    localparam int PW = fifo_ptr_w(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW:0]       count_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap on their own because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count_q == (PW+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;

endmodule

// File: rtl/bidir_bus_master.sv
// Tri-state bus master turning a command stream into RD write/read windows.
// Optional echo checker (chk_err port) enabled by BIDIR_BUS_MASTER_CHECK_EN.
module bidir_bus_master
    import bidir_bus_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int WR_CYC    = 1,
    parameter int RD_CYC    = 2,
    parameter int RSP_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    bidir_bus_master_if.master sys,
    output logic              RD,
    inout  wire [DATA_W-1:0]  data_bus,
`ifdef BIDIR_BUS_MASTER_CHECK_EN
    output logic              chk_err,
`endif
    output logic              busy
);

    localparam int PW      = fifo_ptr_w(RSP_DEPTH);
    localparam int CNT_MAX = (WR_CYC > RD_CYC) ? WR_CYC : RD_CYC;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_e            state_q;
    logic [DATA_W-1:0] hold_q;
    logic [CW-1:0]     cnt_q;
    logic              rd_q;

    logic              accept;
    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [PW:0]       fifo_count;

    assign sys.cmd_ready = (state_q == IDLE) &&
                           (fifo_count < (PW+1)'(RSP_DEPTH));
    assign accept = sys.cmd_valid && sys.cmd_ready;
    assign push   = (state_q == READ) && (cnt_q == '0) && !fifo_full;
    assign pop    = sys.rsp_valid && sys.rsp_ready;

    // Direction and drive both come straight from flops, so the
    // master releases the bus on the same edge RD rises
    assign data_bus = rd_q ? {DATA_W{1'bz}} : hold_q;
    assign RD       = rd_q;
    assign busy     = (state_q != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            rd_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (sys.cmd_write) begin
                            hold_q  <= sys.cmd_data;
                            cnt_q   <= CW'(WR_CYC - 1);
                            state_q <= WRITE;
                        end else begin
                            rd_q    <= 1'b1;
                            cnt_q   <= CW'(RD_CYC - 1);
                            state_q <= READ;
                        end
                    end
                end
                WRITE: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                READ: begin
                    if (cnt_q == '0) begin
                        rd_q    <= 1'b0;
                        state_q <= RECOVER;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RECOVER: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    bbm_rsp_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (data_bus),
        .pop       (pop),
        .pop_data  (sys.rsp_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign sys.rsp_valid = !fifo_empty;

`ifdef BIDIR_BUS_MASTER_CHECK_EN
    logic [DATA_W-1:0] exp_q;

    // The slave echoes the last captured value shifted left by one
    always_ff @(posedge clk) begin
        if (rst) begin
            exp_q   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (accept && !sys.cmd_write) begin
                exp_q <= hold_q << 1;
            end
            if (push && (data_bus != exp_q)) begin
                chk_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bidir_bus_master.sv
// Scoreboard bench for bidir_bus_master with a shift-left echo slave model.
module tb_bidir_bus_master;
    import bidir_bus_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bidir_bus_master_if #(.DATA_W(8)) sys ();

    wire  [7:0] data_bus;
    logic       rd;
    logic       busy;
`ifdef BIDIR_BUS_MASTER_CHECK_EN
    logic       chk_err;
`endif

    bidir_bus_master #(
        .DATA_W    (8),
        .WR_CYC    (1),
        .RD_CYC    (2),
        .RSP_DEPTH (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sys      (sys),
        .RD       (rd),
        .data_bus (data_bus),
`ifdef BIDIR_BUS_MASTER_CHECK_EN
        .chk_err  (chk_err),
`endif
        .busy     (busy)
    );

    // Slave: re-latches the bus while RD=0, echoes it shifted left while RD=1
    logic [7:0] sreg = 8'h00;
    logic       force_zero = 1'b0;
    logic [7:0] slave_val;
    assign slave_val = force_zero ? 8'h00 : {sreg[6:0], 1'b0};
    assign data_bus  = rd ? slave_val : 8'hzz;
    always @(posedge clk) if (!rd) sreg <= data_bus;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] sb[$];
    logic [7:0] model = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && sys.rsp_valid && sys.rsp_ready) begin
            if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else chk("rsp_data", {24'h0, sys.rsp_data}, {24'h0, sb.pop_front()});
        end
    end

    always @(negedge clk) begin
        if (!rst && rd) chk("rd_bus", {24'h0, data_bus}, {24'h0, slave_val});
    end

    task automatic send(input logic wr, input logic [7:0] d, input bit track);
        bit ok;
        ok = 1'b0;
        sys.cmd_valid = 1'b1;
        sys.cmd_write = wr;
        sys.cmd_data  = d;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (sys.cmd_ready) begin
                ok = 1'b1;
                if (wr) model = d;
                else if (track) sb.push_back(force_zero ? 8'h00 : {model[6:0], 1'b0});
                @(posedge clk);
                #1;
            end
        end
        if (!ok) chk("cmd_timeout", 32'd0, 32'd1);
        sys.cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        sys.cmd_valid = 1'b0;
        sys.cmd_write = 1'b0;
        sys.cmd_data  = 8'h00;
        sys.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rd", {31'h0, rd}, 32'd0);
        chk("rst_bus", {24'h0, data_bus}, 32'h00);
        chk("rst_ready", {31'h0, sys.cmd_ready}, 32'd1);
        chk("rst_rsp_valid", {31'h0, sys.rsp_valid}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);

        // Write 35 then read: echo 6A after RD_CYC+1 edges
        send(1'b1, 8'h35, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        @(negedge clk);
        chk("rd_hi_1", {31'h0, rd}, 32'd1);
        chk("rsp_early_1", {31'h0, sys.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("rd_hi_2", {31'h0, rd}, 32'd1);
        chk("rsp_early_2", {31'h0, sys.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("recover_rd", {31'h0, rd}, 32'd0);
        chk("recover_bus", {24'h0, data_bus}, 32'h35);
        chk("recover_busy", {31'h0, busy}, 32'd1);
        chk("rsp_on_time", {31'h0, sys.rsp_valid}, 32'd1);
        @(negedge clk);

        // MSB dropped by the shift
        send(1'b1, 8'hC3, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
`ifdef BIDIR_BUS_MASTER_CHECK_EN
        chk("chk_err_clean", {31'h0, chk_err}, 32'd0);
        force_zero = 1'b1;
        send(1'b0, 8'h00, 1'b1);
        repeat (3) @(negedge clk);
        #1 force_zero = 1'b0;
        @(negedge clk);
        chk("chk_err_set", {31'h0, chk_err}, 32'd1);
        send(1'b0, 8'h00, 1'b1);
        repeat (4) @(negedge clk);
        chk("chk_err_sticky", {31'h0, chk_err}, 32'd1);
`endif

        // Fill the response FIFO; order and wrap checked by the scoreboard
        @(posedge clk);
        #1 sys.rsp_ready = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            send(1'b1, 8'(k), 1'b1);
            send(1'b0, 8'h00, 1'b1);
        end
        repeat (5) @(negedge clk);
        chk("full_ready", {31'h0, sys.cmd_ready}, 32'd0);
        chk("full_rsp_valid", {31'h0, sys.rsp_valid}, 32'd1);
        chk("full_busy", {31'h0, busy}, 32'd0);
        @(posedge clk);
        #1 sys.rsp_ready = 1'b1;
        @(posedge clk);
        #1 sys.rsp_ready = 1'b0;
        @(negedge clk);
        chk("pop_ready", {31'h0, sys.cmd_ready}, 32'd1);
        send(1'b1, 8'h05, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        sys.rsp_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("fill_drain", sb.size(), 32'd0);

        // Reset in the second READ cycle discards the read
        send(1'b1, 8'h7E, 1'b1);
        send(1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model = 8'h00;
        @(negedge clk);
        chk("mid_rst_rd", {31'h0, rd}, 32'd0);
        chk("mid_rst_bus", {24'h0, data_bus}, 32'h00);
        chk("mid_rst_rsp", {31'h0, sys.rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'h0, sys.cmd_ready}, 32'd1);
        repeat (4) @(negedge clk);
        chk("mid_rst_no_rsp", {31'h0, sys.rsp_valid}, 32'd0);

        // Back-to-back with cmd_valid held
        send(1'b1, 8'h5A, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        send(1'b1, 8'h99, 1'b1);
        send(1'b0, 8'h00, 1'b1);
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("b2b_recover_rd", {31'h0, rd}, 32'd0);
        chk("b2b_recover_bus", {24'h0, data_bus}, 32'h99);

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        chk("final_drain", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
